module_captura_numero: RTL and testbench

//   Consumer end of the keypad scanner's output interface. Takes the debounced
//   key-press level and 4-bit hex key code from the scanner.

---
 rtl/module_captura_numero.sv | 118 +++++++++++
 tb/tb_module_captura_numero.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/module_captura_numero.sv
// Keypad operand capture: builds a BCD number from debounced key codes and
// hands it downstream over a valid/ready handshake.
module module_captura_numero #(
  parameter int N_DIG = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tecla,
  input  logic [3:0]                 cod_i,
  input  logic                       ready_i,
  output logic                       valid_o,
  output logic [4*N_DIG-1:0]         num_o,
  output logic [$clog2(N_DIG+1)-1:0] ndig_o,
  output logic                       err_o
);

  localparam int W  = $clog2(N_DIG + 1);
  localparam int BW = 4 * N_DIG;
  localparam logic [W-1:0] MAX_DIG = W'(N_DIG);

  localparam logic [3:0] KEY_CLEAR = 4'hE;
  localparam logic [3:0] KEY_ENTER = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    HOLD
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [BW-1:0] operand;
  logic [BW-1:0] operand_nxt;
  logic [W-1:0]  ndig;
  logic [W-1:0]  ndig_nxt;
  logic          err_q;
  logic          err_nxt;
  logic          tecla_prev;
  logic          key_event;
  logic          is_digit;

  // A key counts once, on the cycle its level rises.
  assign key_event = tecla & ~tecla_prev;
  assign is_digit  = (cod_i <= 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      operand    <= '0;
      ndig       <= '0;
      err_q      <= 1'b0;
      tecla_prev <= 1'b0;
    end else begin
      state      <= state_nxt;
      operand    <= operand_nxt;
      ndig       <= ndig_nxt;
      err_q      <= err_nxt;
      tecla_prev <= tecla;
    end
  end

  always_comb begin
    state_nxt   = state;
    operand_nxt = operand;
    ndig_nxt    = ndig;
    err_nxt     = 1'b0;

    case (state)
      IDLE, ENTRY: begin
        if (key_event) begin
          if (is_digit) begin
            if (ndig < MAX_DIG) begin
              operand_nxt = {operand[BW-5:0], cod_i};
              ndig_nxt    = ndig + W'(1);
              state_nxt   = ENTRY;
            end else begin
              err_nxt = 1'b1;
            end
          end else if (cod_i == KEY_CLEAR) begin
            operand_nxt = '0;
            ndig_nxt    = '0;
            state_nxt   = IDLE;
          end else if (cod_i == KEY_ENTER) begin
            // An empty operand is never offered downstream.
            if (state == IDLE) begin
              err_nxt = 1'b1;
            end else begin
              state_nxt = HOLD;
            end
          end
        end
      end

      HOLD: begin
        if (ready_i) begin
          operand_nxt = '0;
          ndig_nxt    = '0;
          state_nxt   = IDLE;
        end
        if (key_event) begin
          err_nxt = 1'b1;
        end
      end

      default: begin
        operand_nxt = '0;
        ndig_nxt    = '0;
        state_nxt   = IDLE;
      end
    endcase
  end

  assign valid_o = (state == HOLD);
  assign num_o   = operand;
  assign ndig_o  = ndig;
  assign err_o   = err_q;

endmodule

// File: tb/tb_module_captura_numero.sv
// Scoreboard bench for module_captura_numero: expected transfers and error
// pulses are queued by the stimulus and consumed by an independent monitor.
module tb_module_captura_numero;

  logic        clk;
  logic        rst;
  logic        tecla;
  logic [3:0]  cod_i;
  logic        ready_i;
  logic        valid_o;
  logic [11:0] num_o;
  logic [1:0]  ndig_o;
  logic        err_o;

  typedef struct {
    logic [11:0] num;
    logic [1:0]  ndig;
  } xfer_t;

  xfer_t xq[$];
  string eq[$];
  xfer_t mon_x;
  string mon_tag;

  int n_cmp;
  int n_fail;

  module_captura_numero #(.N_DIG(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .tecla   (tecla),
    .cod_i   (cod_i),
    .ready_i (ready_i),
    .valid_o (valid_o),
    .num_o   (num_o),
    .ndig_o  (ndig_o),
    .err_o   (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Press one key for hold_cycles cycles, then release for one cycle.
  task automatic applyStimulus(input logic [3:0] code, input int hold_cycles);
    tecla = 1'b1;
    cod_i = code;
    repeat (hold_cycles) @(posedge clk);
    #1;
    tecla = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string name, input logic v,
                            input logic [11:0] n, input logic [1:0] d);
    checkOutput({name, "_valid"}, 32'(valid_o), 32'(v));
    checkOutput({name, "_num"},   32'(num_o),   32'(n));
    checkOutput({name, "_ndig"},  32'(ndig_o),  32'(d));
  endtask

  task automatic doHandshake(input logic [11:0] n, input logic [1:0] d);
    xq.push_back('{num: n, ndig: d});
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    checkState("after_xfer", 1'b0, 12'h000, 2'd0);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst && valid_o && ready_i) begin
      if (xq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL unexpected_xfer: got num %0h, expected no transfer", num_o);
      end else begin
        mon_x = xq.pop_front();
        checkOutput("xfer_num",  32'(num_o),  32'(mon_x.num));
        checkOutput("xfer_ndig", 32'(ndig_o), 32'(mon_x.ndig));
      end
    end
    if (err_o) begin
      if (eq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL unexpected_err: got err_o 1, expected 0");
      end else begin
        mon_tag = eq.pop_front();
        checkOutput({"err_", mon_tag}, 32'(err_o), 32'd1);
      end
    end
  end

  initial begin
    #500000;
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    rst     = 1'b1;
    tecla   = 1'b0;
    cod_i   = 4'h0;
    ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkState("reset", 1'b0, 12'h000, 2'd0);
    checkOutput("reset_err", 32'(err_o), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] test 1: 1,2,3,#");
    applyStimulus(4'h1, 1);
    checkState("t1_d1", 1'b0, 12'h001, 2'd1);
    applyStimulus(4'h2, 1);
    applyStimulus(4'h3, 1);
    checkState("t1_d3", 1'b0, 12'h123, 2'd3);
    tecla = 1'b1;
    cod_i = 4'hF;
    checkOutput("t1_valid_before_edge", 32'(valid_o), 32'd0);
    @(posedge clk);
    #1;
    checkState("t1_hold", 1'b1, 12'h123, 2'd3);
    tecla = 1'b0;
    @(posedge clk);
    #1;
    doHandshake(12'h123, 2'd3);

    $display("[TB] test 2: overflow digit");
    applyStimulus(4'h1, 1);
    applyStimulus(4'h2, 1);
    applyStimulus(4'h3, 1);
    eq.push_back("full");
    applyStimulus(4'h4, 1);
    checkState("t2_full", 1'b0, 12'h123, 2'd3);
    applyStimulus(4'hE, 1);
    checkState("t2_clear", 1'b0, 12'h000, 2'd0);

    $display("[TB] test 3: enter with no digits");
    eq.push_back("empty_enter");
    applyStimulus(4'hF, 1);
    checkState("t3_idle", 1'b0, 12'h000, 2'd0);
    applyStimulus(4'hE, 1);
    checkState("t3_clear_idle", 1'b0, 12'h000, 2'd0);

    $display("[TB] test 4: 7,5,*,9,# with ignored code B");
    applyStimulus(4'h7, 1);
    applyStimulus(4'h5, 1);
    applyStimulus(4'hB, 1);
    checkState("t4_ignored", 1'b0, 12'h075, 2'd2);
    applyStimulus(4'hE, 1);
    applyStimulus(4'h9, 1);
    applyStimulus(4'hF, 1);
    checkState("t4_hold", 1'b1, 12'h009, 2'd1);
    doHandshake(12'h009, 2'd1);

    $display("[TB] test 5: key held 50 cycles");
    applyStimulus(4'h4, 50);
    checkState("t5_held", 1'b0, 12'h004, 2'd1);
    applyStimulus(4'hE, 1);

    $display("[TB] test 6: hold stability, keys in HOLD, reset");
    applyStimulus(4'h8, 1);
    applyStimulus(4'h2, 1);
    applyStimulus(4'hF, 1);
    repeat (5) @(posedge clk);
    #1;
    eq.push_back("hold_key");
    applyStimulus(4'h8, 3);
    eq.push_back("hold_clear");
    applyStimulus(4'hE, 1);
    repeat (10) @(posedge clk);
    #1;
    checkState("t6_stable", 1'b1, 12'h082, 2'd2);
    eq.push_back("key_with_ready");
    xq.push_back('{num: 12'h082, ndig: 2'd2});
    tecla   = 1'b1;
    cod_i   = 4'h6;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    tecla   = 1'b0;
    ready_i = 1'b0;
    checkState("t6_xfer_and_key", 1'b0, 12'h000, 2'd0);
    @(posedge clk);
    #1;

    applyStimulus(4'h6, 1);
    applyStimulus(4'h3, 1);
    checkState("t6_mid_entry", 1'b0, 12'h063, 2'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkState("t6_rst_entry", 1'b0, 12'h000, 2'd0);
    applyStimulus(4'h5, 1);
    applyStimulus(4'hF, 1);
    checkState("t6_hold5", 1'b1, 12'h005, 2'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkState("t6_rst_hold", 1'b0, 12'h000, 2'd0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("err_queue_drained",  32'(eq.size()), 32'd0);
    checkOutput("xfer_queue_drained", 32'(xq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
